// File: rtl/regfile_arbiter_pkg.sv
// regfile_arbiter_pkg
// Shared types and constants for the register-file arbiter:
//   - sequencer state encoding (IDLE / ISSUE / RWAIT)
//   - default data / address widths of the 4x4-bit register file
//   - requester port identifiers used by the round-robin pointer
package regfile_arbiter_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 2;

  // Port identifiers; the round-robin pointer stores one of these.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-input round-robin arbiter. A lone requester always wins; on a tie the
// port that was not granted last wins. The last-grant pointer only moves
// when a grant is actually issued.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (pointer set so port A wins first tie)
//   en   - arbitration enable; no grant is issued while low
//   req  - request vector, bit 0 = port A, bit 1 = port B
//   gnt  - one-hot grant vector, same bit order as req
module rr_arbiter2
  import regfile_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  // Winner selection from the request vector and the last-grant pointer.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last == PORT_A) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Last-grant pointer; resets to B so that A takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PORT_B;
    end else if (gnt != 2'b00) begin
      last <= gnt[1];
    end else begin
      last <= last;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter
// Arbitrates read/write requests from two clients (A, B) and sequences them
// one at a time onto a 4x4-bit register file. Reads return data on the shared
// rdata bus, qualified by the issuing port's rvalid pulse.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   req_*/we_*/addr_*/wdata_*    - client request (held until gnt_*)
//   gnt_*                        - one-cycle acceptance pulse (IDLE cycle)
//   rvalid_*, rdata              - read response pulse and shared read data
//   busy                         - high whenever the sequencer is not IDLE
//   write_enable, write_in_data, write_in_address - register-file write side
//   read_enable, read_out_address, Led            - register-file read side
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              write_enable,
  output logic              read_enable,
  output logic [DATA_W-1:0] write_in_data,
  output logic [ADDR_W-1:0] write_in_address,
  output logic [ADDR_W-1:0] read_out_address,
  input  logic [DATA_W-1:0] Led
);

  // RWAIT counts down from READ_LATENCY-1 to 0; the capture happens at 0.
  localparam logic [1:0] LAT_INIT = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        lat_cnt;
  logic [1:0]        lat_cnt_nxt;
  logic [1:0]        arb_gnt;
  logic              arb_en;
  logic              accept;
  logic              capture;
  logic              we_nxt;
  logic              re_nxt;
  logic              rvalid_a_nxt;
  logic              rvalid_b_nxt;

  logic              cmd_we;
  logic              cmd_owner;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Grants are only offered in IDLE and never while reset is applied.
  assign arb_en = (state == IDLE) && !rst;
  assign accept = (arb_gnt != 2'b00);

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({req_b, req_a}),
    .gnt (arb_gnt)
  );

  assign gnt_a = arb_gnt[0];
  assign gnt_b = arb_gnt[1];

  // One latched address serves both register-file address ports.
  assign write_in_address = cmd_addr;
  assign read_out_address = cmd_addr;
  assign write_in_data    = cmd_wdata;

  // Mux the winning requester's command onto the latch inputs.
  always_comb begin
    if (arb_gnt[1]) begin
      sel_we    = we_b;
      sel_addr  = addr_b;
      sel_wdata = wdata_b;
    end else begin
      sel_we    = we_a;
      sel_addr  = addr_a;
      sel_wdata = wdata_a;
    end
  end

  // Next-state and next-output decode; strobes are registered so each
  // control reflects the state being entered.
  always_comb begin
    state_nxt    = state;
    lat_cnt_nxt  = lat_cnt;
    we_nxt       = 1'b0;
    re_nxt       = 1'b0;
    rvalid_a_nxt = 1'b0;
    rvalid_b_nxt = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ISSUE;
          we_nxt    = sel_we;
          re_nxt    = !sel_we;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_we) begin
          state_nxt = IDLE;
        end else if (READ_LATENCY == 0) begin
          // Zero-latency file: Led is already valid in the issue cycle.
          state_nxt    = IDLE;
          capture      = 1'b1;
          rvalid_a_nxt = (cmd_owner == PORT_A);
          rvalid_b_nxt = (cmd_owner == PORT_B);
        end else begin
          state_nxt   = RWAIT;
          re_nxt      = 1'b1;
          lat_cnt_nxt = LAT_INIT;
        end
      end
      RWAIT: begin
        if (lat_cnt == 2'd0) begin
          state_nxt    = IDLE;
          capture      = 1'b1;
          rvalid_a_nxt = (cmd_owner == PORT_A);
          rvalid_b_nxt = (cmd_owner == PORT_B);
        end else begin
          lat_cnt_nxt = lat_cnt - 2'd1;
          re_nxt      = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, command latch, response and register-file control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_cnt      <= 2'd0;
      cmd_we       <= 1'b0;
      cmd_owner    <= PORT_A;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      rdata        <= '0;
      rvalid_a     <= 1'b0;
      rvalid_b     <= 1'b0;
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      lat_cnt      <= lat_cnt_nxt;
      rvalid_a     <= rvalid_a_nxt;
      rvalid_b     <= rvalid_b_nxt;
      write_enable <= we_nxt;
      read_enable  <= re_nxt;
      busy         <= (state_nxt != IDLE);
      if (accept) begin
        cmd_we    <= sel_we;
        cmd_owner <= arb_gnt[1];
        cmd_addr  <= sel_addr;
        cmd_wdata <= sel_wdata;
      end
      if (capture) begin
        rdata <= Led;
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter
// Directed bench for regfile_arbiter. Two instances share the clock and
// reset: dut1 with READ_LATENCY=1 in front of a registered-read register
// file model, dut0 with READ_LATENCY=0 in front of a combinational-read
// model. Expected read responses are queued when a read is requested and
// compared when rvalid appears.
module tb_regfile_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       req_a1, req_b1, we_a1, we_b1;
  logic [1:0] addr_a1, addr_b1, waddr1, raddr1;
  logic [3:0] wdata_a1, wdata_b1, rdata1, wdat1, led1;
  logic       gnt_a1, gnt_b1, rvalid_a1, rvalid_b1, busy1, wen1, ren1;

  logic       req_a0, req_b0, we_a0, we_b0;
  logic [1:0] addr_a0, addr_b0, waddr0, raddr0;
  logic [3:0] wdata_a0, wdata_b0, rdata0, wdat0, led0;
  logic       gnt_a0, gnt_b0, rvalid_a0, rvalid_b0, busy0, wen0, ren0;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboards: {port (1 = B), data}
  logic [4:0] sb1[$];
  logic [4:0] sb0[$];
  logic [4:0] e1, e0;

  logic [3:0] mem1 [4];
  logic [3:0] mem0 [4];

  regfile_arbiter #(.DATA_W(4), .ADDR_W(2), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_a(req_a1), .req_b(req_b1), .we_a(we_a1), .we_b(we_b1),
    .addr_a(addr_a1), .addr_b(addr_b1), .wdata_a(wdata_a1), .wdata_b(wdata_b1),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .rvalid_a(rvalid_a1), .rvalid_b(rvalid_b1),
    .rdata(rdata1), .busy(busy1), .write_enable(wen1), .read_enable(ren1),
    .write_in_data(wdat1), .write_in_address(waddr1), .read_out_address(raddr1),
    .Led(led1)
  );

  regfile_arbiter #(.DATA_W(4), .ADDR_W(2), .READ_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_a(req_a0), .req_b(req_b0), .we_a(we_a0), .we_b(we_b0),
    .addr_a(addr_a0), .addr_b(addr_b0), .wdata_a(wdata_a0), .wdata_b(wdata_b0),
    .gnt_a(gnt_a0), .gnt_b(gnt_b0), .rvalid_a(rvalid_a0), .rvalid_b(rvalid_b0),
    .rdata(rdata0), .busy(busy0), .write_enable(wen0), .read_enable(ren0),
    .write_in_data(wdat0), .write_in_address(waddr0), .read_out_address(raddr0),
    .Led(led0)
  );

  // Register file with a one-cycle registered read port.
  always @(posedge clk) begin
    if (wen1) mem1[waddr1] <= wdat1;
    if (ren1) led1 <= mem1[raddr1];
  end

  // Register file with a combinational read port.
  always @(posedge clk) begin
    if (wen0) mem0[waddr0] <= wdat0;
  end
  assign led0 = mem0[raddr0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_checks++;
    assert (obs === expd) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
    end
  endtask

  // Start of a cycle: drive point just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point in the middle of the current cycle.
  task automatic smp();
    @(negedge clk);
  endtask

  // Response scoreboards and protocol invariants, checked every cycle.
  always @(negedge clk) begin
    chk("one_gnt1", 32'(gnt_a1 & gnt_b1), 32'd0);
    chk("we_re_excl1", 32'(wen1 & ren1), 32'd0);
    chk("we_re_excl0", 32'(wen0 & ren0), 32'd0);
    if (rvalid_a1 || rvalid_b1) begin
      chk("sb1_pending", 32'(sb1.size() != 0), 32'd1);
      if (sb1.size() != 0) begin
        e1 = sb1.pop_front();
        chk("sb1_port", 32'({rvalid_b1, rvalid_a1}), 32'(e1[4] ? 2'b10 : 2'b01));
        chk("sb1_rdata", 32'(rdata1), 32'(e1[3:0]));
      end
    end
    if (rvalid_a0 || rvalid_b0) begin
      chk("sb0_pending", 32'(sb0.size() != 0), 32'd1);
      if (sb0.size() != 0) begin
        e0 = sb0.pop_front();
        chk("sb0_port", 32'({rvalid_b0, rvalid_a0}), 32'(e0[4] ? 2'b10 : 2'b01));
        chk("sb0_rdata", 32'(rdata0), 32'(e0[3:0]));
      end
    end
  end

  initial begin
    int cyc_n;
    int idx;
    int exp_cyc;

    rst = 1'b1;
    req_a1 = 1'b0; req_b1 = 1'b0; we_a1 = 1'b0; we_b1 = 1'b0;
    addr_a1 = 2'd0; addr_b1 = 2'd0; wdata_a1 = 4'h0; wdata_b1 = 4'h0;
    req_a0 = 1'b0; req_b0 = 1'b0; we_a0 = 1'b0; we_b0 = 1'b0;
    addr_a0 = 2'd0; addr_b0 = 2'd0; wdata_a0 = 4'h0; wdata_b0 = 4'h0;

    // Reset for 3 cycles with A's write already pending.
    req_a1 = 1'b1; we_a1 = 1'b1; addr_a1 = 2'd2; wdata_a1 = 4'hF;
    repeat (3) begin
      cyc(); smp();
      chk("rst_out1", 32'({gnt_a1, gnt_b1, rvalid_a1, rvalid_b1, busy1, wen1, ren1,
                           rdata1, wdat1, waddr1, raddr1}), 32'd0);
      chk("rst_out0", 32'({gnt_a0, gnt_b0, rvalid_a0, rvalid_b0, busy0, wen0, ren0,
                           rdata0, wdat0, waddr0, raddr0}), 32'd0);
    end

    // Single write: gnt at N, write strobe at N+1, idle at N+2.
    cyc(); rst = 1'b0;
    smp(); chk("t1_gnt", 32'({gnt_a1, gnt_b1, busy1}), 32'(3'b100));
    cyc(); req_a1 = 1'b0;
    smp(); chk("t1_write", 32'({wen1, ren1, busy1, waddr1, wdat1}),
               32'({1'b1, 1'b0, 1'b1, 2'd2, 4'hF}));
    cyc();
    smp(); chk("t1_idle", 32'({busy1, wen1}), 32'd0);

    // B reads addr 2 back.
    cyc(); req_b1 = 1'b1; we_b1 = 1'b0; addr_b1 = 2'd2; sb1.push_back({1'b1, 4'hF});
    smp(); chk("t2_gnt", 32'({gnt_a1, gnt_b1}), 32'(2'b01));
    cyc(); req_b1 = 1'b0;
    smp(); chk("t2_read1", 32'({ren1, wen1, raddr1}), 32'({1'b1, 1'b0, 2'd2}));
    cyc();
    smp(); chk("t2_read2", 32'({ren1, rvalid_b1, raddr1}), 32'({1'b1, 1'b0, 2'd2}));
    cyc();
    smp(); chk("t2_resp", 32'({ren1, rvalid_a1, rvalid_b1, busy1, rdata1}),
               32'({1'b0, 1'b0, 1'b1, 1'b0, 4'hF}));

    // Reset, then both ports hold write requests: grants A, B, A, B.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    req_a1 = 1'b1; we_a1 = 1'b1; addr_a1 = 2'd1; wdata_a1 = 4'h1;
    req_b1 = 1'b1; we_b1 = 1'b1; addr_b1 = 2'd3; wdata_b1 = 4'h2;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) cyc();
      smp();
      if (i == 0) chk("t3_rdata_reset", 32'(rdata1), 32'd0);
      if ((i % 2) == 0) begin
        chk("t3_grant", 32'({gnt_a1, gnt_b1}), 32'(((i % 4) == 0) ? 2'b10 : 2'b01));
      end else if (((i - 1) % 4) == 0) begin
        chk("t3_write_a", 32'({wen1, gnt_a1, gnt_b1, waddr1, wdat1}),
            32'({1'b1, 1'b0, 1'b0, 2'd1, 4'h1}));
      end else begin
        chk("t3_write_b", 32'({wen1, gnt_a1, gnt_b1, waddr1, wdat1}),
            32'({1'b1, 1'b0, 1'b0, 2'd3, 4'h2}));
      end
    end
    cyc(); req_a1 = 1'b0; req_b1 = 1'b0;
    smp(); chk("t3_idle", 32'({busy1, gnt_a1, gnt_b1}), 32'd0);

    // A alone: 4 writes then 4 reads, next command presented after each gnt.
    cyc();
    req_a1 = 1'b1; we_a1 = 1'b1; addr_a1 = 2'd0; wdata_a1 = 4'h3;
    cyc_n = 0; idx = 0; exp_cyc = 0;
    while (idx < 8 && cyc_n < 40) begin
      smp();
      if (gnt_a1) begin
        chk("t4_gnt_cycle", 32'(cyc_n), 32'(exp_cyc));
        if (idx >= 4) sb1.push_back({1'b0, 4'(idx - 1)});
        exp_cyc = exp_cyc + ((idx < 4) ? 2 : 3);
        idx++;
      end
      cyc(); cyc_n++;
      if (idx < 8) begin
        we_a1 = (idx < 4);
        addr_a1 = 2'(idx % 4);
        wdata_a1 = 4'(3 + (idx % 4));
      end else begin
        req_a1 = 1'b0;
      end
    end
    chk("t4_all_granted", 32'(idx), 32'd8);
    repeat (4) begin cyc(); smp(); end
    chk("t4_drained", 32'(sb1.size()), 32'd0);

    // Reset during the RWAIT cycle of a B read: response is dropped.
    cyc(); req_b1 = 1'b1; we_b1 = 1'b0; addr_b1 = 2'd2;
    smp(); chk("t5_gnt", 32'({gnt_a1, gnt_b1}), 32'(2'b01));
    cyc(); req_b1 = 1'b0;
    smp(); chk("t5_issue", 32'({ren1, busy1}), 32'(2'b11));
    cyc(); rst = 1'b1;
    smp(); chk("t5_rwait", 32'({ren1, busy1}), 32'(2'b11));
    cyc(); rst = 1'b0;
    smp(); chk("t5_after_rst", 32'({rvalid_a1, rvalid_b1, busy1, ren1, rdata1}), 32'd0);
    cyc();
    smp(); chk("t5_no_rvalid", 32'({rvalid_a1, rvalid_b1}), 32'd0);
    cyc();
    req_a1 = 1'b1; we_a1 = 1'b1; addr_a1 = 2'd0; wdata_a1 = 4'h7;
    req_b1 = 1'b1; we_b1 = 1'b1; addr_b1 = 2'd0; wdata_b1 = 4'h8;
    smp(); chk("t5_tie_a", 32'({gnt_a1, gnt_b1}), 32'(2'b10));
    cyc(); req_a1 = 1'b0; req_b1 = 1'b0;
    smp(); chk("t5_write", 32'({wen1, wdat1}), 32'({1'b1, 4'h7}));
    cyc(); smp();

    // READ_LATENCY=0 instance: write 0xA to addr 1, B reads it back.
    cyc(); req_a0 = 1'b1; we_a0 = 1'b1; addr_a0 = 2'd1; wdata_a0 = 4'hA;
    smp(); chk("t6_gnt_w", 32'({gnt_a0, gnt_b0}), 32'(2'b10));
    cyc(); req_a0 = 1'b0;
    smp(); chk("t6_write", 32'({wen0, waddr0, wdat0}), 32'({1'b1, 2'd1, 4'hA}));
    cyc(); req_b0 = 1'b1; we_b0 = 1'b0; addr_b0 = 2'd1; sb0.push_back({1'b1, 4'hA});
    smp(); chk("t6_gnt_r", 32'({busy0, gnt_a0, gnt_b0}), 32'(3'b001));
    cyc(); req_b0 = 1'b0;
    smp(); chk("t6_read", 32'({ren0, raddr0, rvalid_b0}), 32'({1'b1, 2'd1, 1'b0}));
    cyc();
    smp(); chk("t6_resp", 32'({ren0, rvalid_b0, rdata0, busy0}),
               32'({1'b0, 1'b1, 4'hA, 1'b0}));
    cyc(); smp();
    chk("end_sb1_empty", 32'(sb1.size()), 32'd0);
    chk("end_sb0_empty", 32'(sb0.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
